vec_issue_ctrl: RTL and testbench

- Issue/sequencing controller for the vector execution datapath.
- Accepts one decoded instruction at a time and drives the immediate extender's ImmSrc select, holding it stable for the whole operation.
- Sequences single-cycle vector ALU ops, single-cycle branch redirects, and multi-beat vector load/store (one 32-bit lane per memory handshake across the 256-bit vector).
- Sits between the decode stage and the extender/ALU/memory-interface blocks.

---
 rtl/vec_issue_ctrl.sv | 165 ++++++++++++++++
 tb/tb_vec_issue_ctrl.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/vec_issue_ctrl.sv
// vec_issue_ctrl: issue/sequencing controller for the vector execution datapath.
// Accepts one decoded instruction at a time, holds the extender ImmSrc select,
// and sequences ALU ops, branch redirects and per-lane vector load/store beats.
// Optional build macro: VEC_MEM_TIMEOUT_EN (abort a MEM beat that waits
// TIMEOUT_CYC cycles without mem_ack, pulsing err instead of done).
module vec_issue_ctrl #(
    parameter int unsigned LANES       = 8,
    parameter int unsigned LANE_W      = 3,
    parameter int unsigned TIMEOUT_CYC = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              instr_valid,
    output logic              instr_ready,
    input  logic [1:0]        Op,
    input  logic [1:0]        ImmKind,
    output logic [1:0]        ImmSrc,
    output logic              alu_en,
    output logic              pc_src,
    output logic              mem_req,
    output logic              mem_we,
    input  logic              mem_ack,
    output logic [LANE_W-1:0] lane_idx,
    output logic              busy,
    output logic              done,
    output logic              err
);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_ALU    = 3'd1;
    localparam logic [2:0] S_BR     = 3'd2;
    localparam logic [2:0] S_MEM    = 3'd3;
    localparam logic [2:0] S_RETIRE = 3'd4;

    localparam logic [1:0] OP_ALU      = 2'b00;
    localparam logic [1:0] OP_ST       = 2'b10;
    localparam logic [1:0] OP_BR       = 2'b11;
    localparam logic [1:0] IMM_ILLEGAL = 2'b11;

    localparam logic [LANE_W-1:0] LAST_LANE = LANE_W'(LANES - 1);

    // Reject inconsistent lane-width or zero-timeout configurations at elaboration.
    if ((LANE_W != $clog2(LANES)) || (TIMEOUT_CYC == 0)) begin : g_param_check
        $error("vec_issue_ctrl: LANE_W must equal clog2(LANES) and TIMEOUT_CYC must be nonzero");
    end

    logic [2:0]        state_q,   state_d;
    logic [LANE_W-1:0] lane_q,    lane_d;
    logic [1:0]        imm_src_q, imm_src_d;
    logic              mem_we_q,  mem_we_d;
    logic              ready_q,   ready_d;
    logic              err_q,     err_d;
    logic              accept;

`ifdef VEC_MEM_TIMEOUT_EN
    localparam int unsigned WAIT_W = $clog2(TIMEOUT_CYC + 1);
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(TIMEOUT_CYC - 1);

    logic [WAIT_W-1:0] wait_q, wait_d;
`endif

    // instr_ready is registered, so a handshake needs it already high.
    assign accept = instr_valid && ready_q;

    // Next-state, lane counter, latched select and error pulse.
    always_comb begin
        state_d   = state_q;
        lane_d    = lane_q;
        imm_src_d = imm_src_q;
        mem_we_d  = mem_we_q;
        err_d     = 1'b0;
`ifdef VEC_MEM_TIMEOUT_EN
        wait_d    = '0;
`endif
        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    if (ImmKind == IMM_ILLEGAL) begin
                        // Illegal immediate: drop the instruction, flag it, clear the select.
                        err_d     = 1'b1;
                        imm_src_d = 2'b00;
                    end else begin
                        imm_src_d = ImmKind;
                        mem_we_d  = (Op == OP_ST);
                        lane_d    = '0;
                        case (Op)
                            OP_ALU:  state_d = S_ALU;
                            OP_BR:   state_d = S_BR;
                            default: state_d = S_MEM;
                        endcase
                    end
                end
            end
            S_ALU, S_BR: begin
                state_d = S_RETIRE;
            end
            S_MEM: begin
                if (mem_ack) begin
                    if (lane_q == LAST_LANE) begin
                        state_d = S_RETIRE;
                    end else begin
                        lane_d = lane_q + 1'b1;
                    end
                end
`ifdef VEC_MEM_TIMEOUT_EN
                else if (wait_q == WAIT_LAST) begin
                    state_d = S_IDLE;
                    err_d   = 1'b1;
                end else begin
                    wait_d = wait_q + 1'b1;
                end
`endif
            end
            S_RETIRE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
        ready_d = (state_d == S_IDLE);
    end

    // State and registered-output flops.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= S_IDLE;
            lane_q    <= '0;
            imm_src_q <= 2'b00;
            mem_we_q  <= 1'b0;
            ready_q   <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            lane_q    <= lane_d;
            imm_src_q <= imm_src_d;
            mem_we_q  <= mem_we_d;
            ready_q   <= ready_d;
            err_q     <= err_d;
        end
    end

`ifdef VEC_MEM_TIMEOUT_EN
    // Cycles spent in MEM since entry or the last ack.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wait_q <= '0;
        end else begin
            wait_q <= wait_d;
        end
    end
`endif

    assign instr_ready = ready_q;
    assign ImmSrc      = imm_src_q;
    assign mem_we      = mem_we_q;
    assign lane_idx    = lane_q;
    assign err         = err_q;
    assign busy        = (state_q != S_IDLE);
    assign alu_en      = (state_q == S_ALU);
    assign pc_src      = (state_q == S_BR);
    assign mem_req     = (state_q == S_MEM);
    assign done        = (state_q == S_RETIRE);

endmodule

// File: tb/tb_vec_issue_ctrl.sv
// Testbench for vec_issue_ctrl: transaction-level reference with random acks.
module tb_vec_issue_ctrl;

    localparam int unsigned LANES  = 8;
    localparam int unsigned LANE_W = 3;

    logic              clk;
    logic              reset;
    logic              instr_valid;
    logic              instr_ready;
    logic [1:0]        Op;
    logic [1:0]        ImmKind;
    logic [1:0]        ImmSrc;
    logic              alu_en;
    logic              pc_src;
    logic              mem_req;
    logic              mem_we;
    logic              mem_ack;
    logic [LANE_W-1:0] lane_idx;
    logic              busy;
    logic              done;
    logic              err;

    int n_cmp = 0;
    int n_err = 0;
    logic [1:0] exp_imm = 2'b00;

    vec_issue_ctrl #(.LANES(LANES), .LANE_W(LANE_W), .TIMEOUT_CYC(16)) dut (
        .clk        (clk),
        .reset      (reset),
        .instr_valid(instr_valid),
        .instr_ready(instr_ready),
        .Op         (Op),
        .ImmKind    (ImmKind),
        .ImmSrc     (ImmSrc),
        .alu_en     (alu_en),
        .pc_src     (pc_src),
        .mem_req    (mem_req),
        .mem_we     (mem_we),
        .mem_ack    (mem_ack),
        .lane_idx   (lane_idx),
        .busy       (busy),
        .done       (done),
        .err        (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_outs(input string tag, input bit e_ready, input bit e_busy, input bit e_alu,
                            input bit e_pc, input bit e_req, input bit e_done, input bit e_err);
        check_eq({tag, ".ready"}, 32'(instr_ready), 32'(e_ready));
        check_eq({tag, ".busy"},  32'(busy),        32'(e_busy));
        check_eq({tag, ".alu"},   32'(alu_en),      32'(e_alu));
        check_eq({tag, ".pc"},    32'(pc_src),      32'(e_pc));
        check_eq({tag, ".req"},   32'(mem_req),     32'(e_req));
        check_eq({tag, ".done"},  32'(done),        32'(e_done));
        check_eq({tag, ".err"},   32'(err),         32'(e_err));
    endtask

    task automatic finish_now();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    endtask

    // Idle gap with stray acks that must be ignored.
    task automatic idle_cycles(input int n);
        for (int i = 0; i < n; i++) begin
            instr_valid = 1'b0;
            mem_ack     = 1'($urandom_range(0, 1));
            chk_outs("idle", 1, 0, 0, 0, 0, 0, 0);
            check_eq("idle.imm", 32'(ImmSrc), 32'(exp_imm));
            tick();
        end
        mem_ack = 1'b0;
    endtask

    // Issue one instruction and follow it to retirement.
    // ack_mode: 0 = ack every cycle, 1 = every 3rd cycle, 2 = random.
    task automatic run_instr(input logic [1:0] op, input logic [1:0] kind, input int ack_mode);
        int  cyc;
        int  lane;
        bit  ack;
        check_eq("accept.ready", 32'(instr_ready), 32'd1);
        instr_valid = 1'b1;
        Op          = op;
        ImmKind     = kind;
        mem_ack     = 1'($urandom_range(0, 1));
        tick();
        mem_ack = 1'b0;
        if (kind == 2'b11) begin
            instr_valid = 1'b0;
            chk_outs("illegal", 1, 0, 0, 0, 0, 0, 1);
            tick();
            chk_outs("illegal.after", 1, 0, 0, 0, 0, 0, 0);
            exp_imm = 2'b00;
            check_eq("illegal.imm", 32'(ImmSrc), 32'(exp_imm));
            return;
        end
        exp_imm = kind;
        // Junk on the decode side while busy must be ignored.
        instr_valid = 1'($urandom_range(0, 1));
        Op          = 2'($urandom);
        ImmKind     = 2'($urandom);
        if (op == 2'b00 || op == 2'b11) begin
            chk_outs("single", 0, 1, (op == 2'b00), (op == 2'b11), 0, 0, 0);
            check_eq("single.imm", 32'(ImmSrc), 32'(exp_imm));
            tick();
            chk_outs("single.done", 0, 1, 0, 0, 0, 1, 0);
            check_eq("single.done.imm", 32'(ImmSrc), 32'(exp_imm));
            tick();
        end else begin
            lane = 0;
            cyc  = 0;
            while (lane < int'(LANES)) begin
                chk_outs("mem", 0, 1, 0, 0, 1, 0, 0);
                check_eq("mem.lane", 32'(lane_idx), 32'(lane));
                check_eq("mem.we",   32'(mem_we),   32'(op == 2'b10));
                check_eq("mem.imm",  32'(ImmSrc),   32'(exp_imm));
                case (ack_mode)
                    0:       ack = 1'b1;
                    1:       ack = ((cyc % 3) == 2);
                    default: ack = 1'($urandom_range(0, 1));
                endcase
                mem_ack = ack;
                tick();
                cyc++;
                if (ack) lane++;
                if (cyc > 500) begin
                    check_eq("mem.budget", 32'(lane), 32'(LANES));
                    finish_now();
                end
            end
            mem_ack = 1'($urandom_range(0, 1));
            chk_outs("mem.done", 0, 1, 0, 0, 0, 1, 0);
            check_eq("mem.done.imm", 32'(ImmSrc), 32'(exp_imm));
            tick();
        end
        instr_valid = 1'b0;
        mem_ack     = 1'b0;
        chk_outs("retired", 1, 0, 0, 0, 0, 0, 0);
        check_eq("retired.imm", 32'(ImmSrc), 32'(exp_imm));
    endtask

    // All outputs must read zero while reset is held.
    task automatic chk_reset_vals(input string tag);
        chk_outs(tag, 0, 0, 0, 0, 0, 0, 0);
        check_eq({tag, ".imm"},  32'(ImmSrc),   32'd0);
        check_eq({tag, ".we"},   32'(mem_we),   32'd0);
        check_eq({tag, ".lane"}, 32'(lane_idx), 32'd0);
    endtask

    // Start a load, then assert reset asynchronously while lane 4 is pending.
    task automatic reset_mid_load();
        int cyc;
        check_eq("rst.accept.ready", 32'(instr_ready), 32'd1);
        instr_valid = 1'b1;
        Op          = 2'b01;
        ImmKind     = 2'b01;
        tick();
        instr_valid = 1'b0;
        cyc = 0;
        while (lane_idx != LANE_W'(4) && cyc < 20) begin
            mem_ack = 1'b1;
            tick();
            cyc++;
        end
        check_eq("rst.lane4", 32'(lane_idx), 32'd4);
        mem_ack = 1'b0;
        #1 reset = 1'b0;
        #1 chk_reset_vals("rst.async");
        tick();
        tick();
        chk_reset_vals("rst.held");
        #2 reset = 1'b1;
        exp_imm = 2'b00;
        tick();
        chk_outs("rst.released", 1, 0, 0, 0, 0, 0, 0);
        check_eq("rst.released.imm", 32'(ImmSrc), 32'd0);
    endtask

    initial begin
        reset       = 1'b1;
        instr_valid = 1'b0;
        Op          = 2'b00;
        ImmKind     = 2'b00;
        mem_ack     = 1'b0;
        #1 reset = 1'b0;
        tick();
        tick();
        chk_reset_vals("por");
        #2 reset = 1'b1;
        tick();
        chk_outs("por.released", 1, 0, 0, 0, 0, 0, 0);

        run_instr(2'b00, 2'b00, 0);
        idle_cycles(2);
        run_instr(2'b01, 2'b01, 0);
        idle_cycles(1);
        run_instr(2'b10, 2'b00, 1);
        idle_cycles(3);
        run_instr(2'b11, 2'b10, 0);
        run_instr(2'b01, 2'b11, 0);
        run_instr(2'b11, 2'b11, 0);
        idle_cycles(1);
        run_instr(2'b11, 2'b00, 0);
        run_instr(2'b11, 2'b01, 0);

        reset_mid_load();
        run_instr(2'b01, 2'b01, 0);

        for (int k = 0; k < 40; k++) begin
            run_instr(2'($urandom), 2'($urandom), int'($urandom_range(0, 2)));
            idle_cycles(int'($urandom_range(0, 2)));
        end

        finish_now();
    end

endmodule
